// File: rtl/i2c_master_reader.sv
// I2C controller that runs a single read transaction and collects three bytes
// (x_pos, y_pos, status) from a read-only target. SCL and SDA are driven open-drain.
module i2c_master_reader #(
  parameter logic [6:0]  I2C_ADDR = 7'h64,
  parameter int unsigned CLK_DIV  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic [7:0] status
);

  localparam int unsigned QW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMax   = QW'(CLK_DIV - 1);
  localparam logic [7:0]  AddrByte = {I2C_ADDR, 1'b1};

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAddrAck, StRead, StMack, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic            nack_q, nack_d;
  logic            sda_meta_q, sda_sync_q;
  logic            scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
  logic [7:0]      x_q, x_d, y_q, y_d, st_q, st_d;
  logic            slot_end, sample;

  assign slot_end = (qcnt_q == QMax) && (phase_q == 2'd3);
  assign sample   = (qcnt_q == QMax) && (phase_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    x_d       = x_q;
    y_d       = y_q;
    st_d      = st_q;

    if (state_q != StIdle) begin
      if (qcnt_q == QMax) begin
        qcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        // The cycle that reports done also refuses a new start.
        if (start && !done_q) begin
          state_d   = StStart;
          qcnt_d    = '0;
          phase_d   = '0;
          bit_d     = '0;
          byte_d    = '0;
          ack_err_d = 1'b0;
        end
      end
      StStart: begin
        if (slot_end) begin
          state_d = StAddr;
          bit_d   = '0;
        end
      end
      StAddr: begin
        if (slot_end) begin
          if (bit_q == 3'd7) state_d = StAddrAck;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StAddrAck: begin
        if (sample) nack_d = sda_sync_q;
        if (slot_end) begin
          if (nack_q) begin
            ack_err_d = 1'b1;
            state_d   = StStop;
          end else begin
            state_d = StRead;
            bit_d   = '0;
            byte_d  = '0;
          end
        end
      end
      StRead: begin
        if (sample) shreg_d = {shreg_q[6:0], sda_sync_q};
        if (slot_end) begin
          if (bit_q == 3'd7) state_d = StMack;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StMack: begin
        if (slot_end) begin
          case (byte_q)
            2'd0:    b0_d = shreg_q;
            2'd1:    b1_d = shreg_q;
            default: b2_d = shreg_q;
          endcase
          if (byte_q == 2'd2) begin
            state_d = StStop;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = '0;
            state_d = StRead;
          end
        end
      end
      StStop: begin
        if (slot_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!ack_err_q) begin
            x_d  = b0_q;
            y_d  = b1_q;
            st_d = b2_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line levels are decoded from the next state so the outputs can be registered.
    busy_d   = (state_d != StIdle);
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      StStart: begin
        sda_oe_d = phase_d[1];
        scl_oe_d = (phase_d == 2'd3);
      end
      StAddr: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = ~AddrByte[3'd7 - bit_d];
      end
      StAddrAck, StRead: scl_oe_d = ~phase_d[1];
      StMack: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = (byte_d != 2'd2);
      end
      StStop: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = ~phase_d[1];
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      qcnt_q     <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      nack_q     <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      st_q       <= '0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      nack_q     <= nack_d;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      x_q        <= x_d;
      y_q        <= y_d;
      st_q       <= st_d;
    end
  end

  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign x_pos   = x_q;
  assign y_pos   = y_q;
  assign status  = st_q;

endmodule
